// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports and two write ports,
// with same-cycle write-to-read bypass, a per-entry busy scoreboard and a post-reset clearing sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                run;
  logic                wr0_en, wr1_en, set_en;

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // Entry 0 is hard-wired when ZERO_REG is set, so its writes and busy marks are dropped here.
  assign wr0_en = run && we0 && !(ZR && (waddr0 == '0));
  assign wr1_en = run && we1 && !(ZR && (waddr1 == '0));
  assign set_en = run && busy_set && !(ZR && (busy_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  // Clear before set so a fresh issue to an address being written back stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wr0_en) busy_d[waddr0] = 1'b0;
    if (wr1_en) busy_d[waddr1] = 1'b0;
    if (set_en) busy_d[busy_addr] = 1'b1;
  end

  // Storage carries no reset; the sweep is what makes every entry defined.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_ptr_q] <= '0;
    end else begin
      if (wr0_en) mem_q[waddr0] <= wdata0;
      if (wr1_en) mem_q[waddr1] <= wdata1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1, zero_hit;
    logic [DATA_W-1:0] rd_val;

    assign ra       = raddr[g*ADDR_W +: ADDR_W];
    assign hit1     = we1 && (waddr1 == ra);
    assign hit0     = we0 && (waddr0 == ra);
    assign zero_hit = ZR && (ra == '0);

    always_comb begin
      rd_val = '0;
      if (run && re[g] && !zero_hit) begin
        if (hit1)      rd_val = wdata1;
        else if (hit0) rd_val = wdata0;
        else           rd_val = mem_q[ra];
      end
    end

    assign rdata[g*DATA_W +: DATA_W] = rd_val;
    assign rd_busy[g] = run && re[g] && busy_q[ra] && !(hit0 || hit1);
  end

endmodule
